// File: rtl/dma_ctrl.sv
// Image DMA sequencer: loads an NxN image into the window buffer, issues window origins, writes results back.
// Latency: N*N read cycles plus one flush cycle before the first origin; each result is written one cycle after res_valid.
// Backpressure: an origin is held stable while win_ready is low; the RAM port itself never stalls.
module dma_ctrl #(
    parameter int ADDR_W = 16,
    parameter int IDX_W  = 5,
    parameter int K      = 5,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              pooling,
    input  logic [5:0]        image_size,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] out_addr,
    output logic [ADDR_W-1:0] ram_address,
    output logic              ram_read,
    output logic              ram_write,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              buf_we,
    output logic [IDX_W-1:0]  buf_row,
    output logic [IDX_W-1:0]  buf_col,
    output logic              win_valid,
    input  logic              win_ready,
    output logic [IDX_W-1:0]  win_row,
    output logic [IDX_W-1:0]  win_col,
    input  logic              res_valid,
    input  logic [DATA_W-1:0] res_data,
    output logic              busy,
    output logic              done,
    output logic              err
);
    localparam int CNT_W = 12;

    typedef enum logic [2:0] {IDLE, LOAD, FLUSH, ISSUE, WAIT, FIN} state_t;

    state_t            state, state_nx;
    logic              pool_q, err_q;
    logic [5:0]        n_q, o_q;
    logic [ADDR_W-1:0] base_q, out_q;
    logic [IDX_W-1:0]  ld_row, ld_col, org_row, org_col;
    logic [CNT_W-1:0]  ld_idx, wr_cnt;
    logic              wr_pend;
    logic [DATA_W-1:0] wr_dat;
    logic              bwe_q;
    logic [IDX_W-1:0]  brow_q, bcol_q;

    logic              size_bad;
    logic [5:0]        o_new, n_m1, o_m1, lim;
    logic [IDX_W-1:0]  step;
    logic [CNT_W-1:0]  total, wr_next;
    logic              ld_last, win_last, wr_act;

    always_comb begin
        size_bad = (image_size > 6'd32) ||
                   (pooling ? (image_size < 6'd2) : (image_size < 6'(K)));
        o_new    = pooling ? {1'b0, image_size[5:1]} : image_size - 6'(K - 1);
        n_m1     = n_q - 6'd1;
        o_m1     = o_q - 6'd1;
        // Last origin coordinate: step*(O-1)
        lim      = pool_q ? (o_m1 << 1) : o_m1;
        step     = pool_q ? IDX_W'(2) : IDX_W'(1);
        total    = CNT_W'(o_q) * CNT_W'(o_q);
        ld_last  = ({1'b0, ld_row} == n_m1) && ({1'b0, ld_col} == n_m1);
        win_last = ({1'b0, org_row} == lim) && ({1'b0, org_col} == lim);
        // A result captured late in WAIT must not leak a write into FIN
        wr_act   = wr_pend && ((state == ISSUE) || (state == WAIT));
        wr_next  = wr_cnt + CNT_W'(wr_act);
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = size_bad ? FIN : LOAD;
            LOAD:    if (ld_last) state_nx = FLUSH;
            FLUSH:   state_nx = ISSUE;
            ISSUE:   if (win_ready && win_last) state_nx = WAIT;
            WAIT:    if (wr_next == total) state_nx = FIN;
            FIN:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        ram_read    = (state == LOAD);
        ram_write   = wr_act;
        ram_address = '0;
        if (ram_read)
            ram_address = base_q + ADDR_W'(ld_idx);
        else if (wr_act)
            ram_address = out_q + ADDR_W'(wr_cnt);
        ram_wdata   = wr_dat;
        buf_we      = bwe_q;
        buf_row     = brow_q;
        buf_col     = bcol_q;
        win_valid   = (state == ISSUE);
        win_row     = win_valid ? org_row : '0;
        win_col     = win_valid ? org_col : '0;
        busy        = (state != IDLE);
        done        = (state == FIN);
        err         = err_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            pool_q  <= 1'b0;
            err_q   <= 1'b0;
            n_q     <= '0;
            o_q     <= '0;
            base_q  <= '0;
            out_q   <= '0;
            ld_row  <= '0;
            ld_col  <= '0;
            ld_idx  <= '0;
            org_row <= '0;
            org_col <= '0;
            wr_cnt  <= '0;
            wr_pend <= 1'b0;
            wr_dat  <= '0;
            bwe_q   <= 1'b0;
            brow_q  <= '0;
            bcol_q  <= '0;
        end else begin
            state   <= state_nx;
            // Buffer write trails the read by one cycle, matching RAM latency
            bwe_q   <= (state == LOAD);
            brow_q  <= ld_row;
            bcol_q  <= ld_col;
            wr_pend <= res_valid && ((state == ISSUE) || (state == WAIT));
            if (res_valid && ((state == ISSUE) || (state == WAIT)))
                wr_dat <= res_data;
            if (wr_act)
                wr_cnt <= wr_cnt + CNT_W'(1);
            case (state)
                IDLE: if (start) begin
                    pool_q  <= pooling;
                    n_q     <= image_size;
                    o_q     <= o_new;
                    base_q  <= base_addr;
                    out_q   <= out_addr;
                    err_q   <= size_bad;
                    ld_row  <= '0;
                    ld_col  <= '0;
                    ld_idx  <= '0;
                    org_row <= '0;
                    org_col <= '0;
                    wr_cnt  <= '0;
                end
                LOAD: begin
                    ld_idx <= ld_idx + CNT_W'(1);
                    if ({1'b0, ld_col} == n_m1) begin
                        ld_col <= '0;
                        ld_row <= ld_row + IDX_W'(1);
                    end else begin
                        ld_col <= ld_col + IDX_W'(1);
                    end
                end
                ISSUE: if (win_ready && !win_last) begin
                    if ({1'b0, org_col} == lim) begin
                        org_col <= '0;
                        org_row <= org_row + step;
                    end else begin
                        org_col <= org_col + step;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_dma_ctrl.sv
// Directed bench for dma_ctrl: negedge monitor logs RAM/buffer/window/result traffic, a 3-cycle engine model returns results.
module tb_dma_ctrl;
    localparam int ADDR_W = 16;
    localparam int IDX_W  = 5;
    localparam int K      = 5;
    localparam int DATA_W = 16;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic              pooling = 1'b0;
    logic [5:0]        image_size = '0;
    logic [ADDR_W-1:0] base_addr = '0;
    logic [ADDR_W-1:0] out_addr = '0;
    logic [ADDR_W-1:0] ram_address;
    logic              ram_read, ram_write;
    logic [DATA_W-1:0] ram_wdata;
    logic              buf_we;
    logic [IDX_W-1:0]  buf_row, buf_col;
    logic              win_valid;
    logic              win_ready = 1'b1;
    logic [IDX_W-1:0]  win_row, win_col;
    logic              res_valid = 1'b0;
    logic [DATA_W-1:0] res_data = '0;
    logic              busy, done, err;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int rd_q[$], bw_q[$], win_q[$], wr_a[$], wr_d[$], stall_q[$];
    int rd_last, bw_last, wr_last, done_cyc, done_cnt, both_hi, err_at_done, stall_left;
    int p_v[3], p_d[3];

    dma_ctrl #(.ADDR_W(ADDR_W), .IDX_W(IDX_W), .K(K), .DATA_W(DATA_W)) dut (
        .clk(clk), .rst(rst), .start(start), .pooling(pooling), .image_size(image_size),
        .base_addr(base_addr), .out_addr(out_addr), .ram_address(ram_address),
        .ram_read(ram_read), .ram_write(ram_write), .ram_wdata(ram_wdata),
        .buf_we(buf_we), .buf_row(buf_row), .buf_col(buf_col),
        .win_valid(win_valid), .win_ready(win_ready), .win_row(win_row), .win_col(win_col),
        .res_valid(res_valid), .res_data(res_data), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Engine model, ready generator and traffic monitor, all away from the active edge
    always @(negedge clk) begin
        win_ready = 1'b1;
        if (stall_left > 0 && win_valid && win_q.size() == 1) begin
            win_ready = 1'b0;
            stall_left--;
        end
        res_valid = (p_v[2] != 0);
        res_data  = DATA_W'(p_d[2]);
        p_v[2] = p_v[1]; p_d[2] = p_d[1];
        p_v[1] = p_v[0]; p_d[1] = p_d[0];
        p_v[0] = (win_valid && win_ready) ? 1 : 0;
        p_d[0] = 'hC000 + int'(win_row) * 32 + int'(win_col);
        if (win_valid && !win_ready) stall_q.push_back(int'(win_row) * 32 + int'(win_col));
        if (win_valid && win_ready) win_q.push_back(int'(win_row) * 32 + int'(win_col));
        if (ram_read) begin rd_q.push_back(int'(ram_address)); rd_last = cyc; end
        if (ram_read && ram_write) both_hi++;
        if (buf_we) begin bw_q.push_back(int'(buf_row) * 32 + int'(buf_col)); bw_last = cyc; end
        if (ram_write) begin
            wr_a.push_back(int'(ram_address));
            wr_d.push_back(int'(ram_wdata));
            wr_last = cyc;
        end
        if (done) begin done_cnt++; done_cyc = cyc; err_at_done = int'(err); end
    end

    task automatic check(input string tag, input int obs, input int exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clear_logs();
        rd_q.delete(); bw_q.delete(); win_q.delete();
        wr_a.delete(); wr_d.delete(); stall_q.delete();
        rd_last = -100; bw_last = -100; wr_last = -100;
        done_cyc = -1; done_cnt = 0; both_hi = 0; err_at_done = -1; stall_left = 0;
    endtask

    task automatic launch(input logic pool, input int n, input int base, input int outa, output int at_cyc);
        @(negedge clk);
        pooling    = pool;
        image_size = 6'(n);
        base_addr  = ADDR_W'(base);
        out_addr   = ADDR_W'(outa);
        start      = 1'b1;
        at_cyc     = cyc;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk);
            if (done_cnt > 0) break;
        end
        check({tag, "_finished"}, (done_cnt > 0) ? 1 : 0, 1);
        repeat (5) @(posedge clk);
    endtask

    task automatic verify(input string tag, input logic pool, input int n, input int base, input int outa);
        int o, step, tot, bad, r, c, ew;
        o    = pool ? n / 2 : n - K + 1;
        step = pool ? 2 : 1;
        tot  = o * o;
        check({tag, "_rd_cnt"}, rd_q.size(), n * n);
        bad = 0;
        foreach (rd_q[i]) if (rd_q[i] != ((base + i) & 'hFFFF)) bad++;
        check({tag, "_rd_addr"}, bad, 0);
        check({tag, "_bw_cnt"}, bw_q.size(), n * n);
        bad = 0;
        foreach (bw_q[i]) if (bw_q[i] != (i / n) * 32 + (i % n)) bad++;
        check({tag, "_bw_idx"}, bad, 0);
        check({tag, "_bw_last_cyc"}, bw_last, rd_last + 1);
        check({tag, "_win_cnt"}, win_q.size(), tot);
        check({tag, "_wr_cnt"}, wr_a.size(), tot);
        bad = 0;
        for (int k = 0; k < tot; k++) begin
            r  = (k / o) * step;
            c  = (k % o) * step;
            ew = r * 32 + c;
            if (k < win_q.size() && win_q[k] != ew) bad++;
            if (k < wr_a.size() && (wr_a[k] != ((outa + k) & 'hFFFF) || wr_d[k] != 'hC000 + ew)) bad++;
        end
        check({tag, "_win_wr_seq"}, bad, 0);
        check({tag, "_done_cnt"}, done_cnt, 1);
        check({tag, "_done_cyc"}, done_cyc, wr_last + 1);
        check({tag, "_err"}, err_at_done, 0);
        check({tag, "_rw_overlap"}, both_hi, 0);
    endtask

    initial begin
        int t0, bad;
        clear_logs();
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_strobes", {ram_read, ram_write, buf_we, win_valid, done, err}, 0);
        check("rst_addr", ram_address, 0);
        rst = 1'b0;

        // Convolution, N=7
        clear_logs();
        launch(1'b0, 7, 'h0100, 'h0400, t0);
        wait_done("conv7");
        verify("conv7", 1'b0, 7, 'h0100, 'h0400);

        // Pooling, N=8, with a start pulse during ISSUE that must be ignored
        clear_logs();
        launch(1'b1, 8, 'h2000, 'h3000, t0);
        for (int i = 0; i < 500 && win_q.size() < 3; i++) @(posedge clk);
        check("pool8_in_issue", win_valid, 1);
        @(negedge clk);
        pooling = 1'b0; image_size = 6'd4; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("pool8");
        verify("pool8", 1'b1, 8, 'h2000, 'h3000);

        // Conv N=6, second window stalled 4 cycles, output addresses wrap
        clear_logs();
        stall_left = 4;
        launch(1'b0, 6, 'h0500, 'hFFFE, t0);
        wait_done("stall6");
        verify("stall6", 1'b0, 6, 'h0500, 'hFFFE);
        check("stall6_len", stall_q.size(), 4);
        bad = 0;
        foreach (stall_q[i]) if (stall_q[i] != 1) bad++;
        check("stall6_origin_stable", bad, 0);

        // Illegal conv size
        clear_logs();
        launch(1'b0, 4, 'h0100, 'h0400, t0);
        wait_done("err4");
        check("err4_err_at_done", err_at_done, 1);
        check("err4_done_cyc", done_cyc, t0 + 1);
        check("err4_done_cnt", done_cnt, 1);
        check("err4_no_traffic", rd_q.size() + wr_a.size() + win_q.size() + bw_q.size(), 0);
        check("err4_sticky", err, 1);

        // Next legal start clears err; input addresses wrap
        clear_logs();
        launch(1'b0, 5, 'hFFF0, 'h0700, t0);
        check("conv5_err_cleared", err, 0);
        wait_done("conv5");
        verify("conv5", 1'b0, 5, 'hFFF0, 'h0700);

        // Reset while LOAD presents i=10
        clear_logs();
        launch(1'b0, 7, 'h0100, 'h0400, t0);
        for (int i = 0; i < 200 && rd_q.size() < 11; i++) begin
            @(negedge clk);
            #1;
        end
        check("rstmid_at_i10", rd_q.size(), 11);
        rst = 1'b1;
        @(negedge clk);
        #1;
        check("rstmid_busy", busy, 0);
        check("rstmid_strobes", {ram_read, ram_write, buf_we, win_valid, done, err}, 0);
        check("rstmid_addr", ram_address, 0);
        check("rstmid_idx", {buf_row, buf_col, win_row, win_col}, 0);
        check("rstmid_wdata", ram_wdata, 0);
        repeat (3) @(negedge clk);
        #1;
        check("rstmid_no_reads", rd_q.size(), 11);
        rst = 1'b0;
        clear_logs();
        launch(1'b0, 7, 'h0100, 'h0400, t0);
        wait_done("after_rst");
        verify("after_rst", 1'b0, 7, 'h0100, 'h0400);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
